// File: rtl/nios2_debug_ocimem_arbiter.sv
// OCI RAM arbiter: sequences JTAG debug and CPU Avalon accesses onto one
// single-port 32-bit RAM through IDLE -> ISSUE -> (CAPTURE) -> IDLE.
module nios2_debug_ocimem_arbiter #(
  parameter int unsigned AW              = 8,
  parameter bit          DBG_PRIO_ON_ACK = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          debugack,
  input  logic          dbg_addr_load,
  input  logic [AW-1:0] dbg_addr,
  input  logic          dbg_req,
  input  logic          dbg_write,
  input  logic [31:0]   dbg_wdata,
  output logic          dbg_pending,
  output logic          dbg_rvalid,
  output logic [31:0]   dbg_rdata,
  output logic          dbg_overflow,
  input  logic          cpu_read,
  input  logic          cpu_write,
  input  logic [AW-1:0] cpu_address,
  input  logic [31:0]   cpu_writedata,
  output logic          cpu_waitrequest,
  output logic [31:0]   cpu_readdata,
  output logic          cpu_readdatavalid,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE} state_t;
  state_t r_state, w_next;

  logic          r_dbg_pending, r_dbg_we, r_dbg_overflow, r_dbg_rvalid;
  logic [31:0]   r_dbg_wdata, r_dbg_rdata, r_cpu_rdata;
  logic          r_cpu_rvalid;
  logic [AW-1:0] r_dbg_cnt, r_ram_addr;
  logic          r_ram_we;
  logic [31:0]   r_ram_wdata;
  logic          r_gnt_dbg, r_last_dbg;
  logic          w_cpu_req, w_grant, w_pick_dbg, w_dbg_done;
  logic [AW-1:0] w_dbg_addr;

  assign w_cpu_req  = cpu_read | cpu_write;
  assign w_dbg_done = (r_state == S_ISSUE) && r_gnt_dbg;
  // A load in the granting cycle still steers the access it grants.
  assign w_dbg_addr = dbg_addr_load ? dbg_addr : r_dbg_cnt;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_cpu_req || r_dbg_pending) w_next = S_ISSUE;
      S_ISSUE:   w_next = r_ram_we ? S_IDLE : S_CAPTURE;
      S_CAPTURE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_grant         = 1'b0;
    w_pick_dbg      = 1'b0;
    ram_en          = (r_state == S_ISSUE);
    cpu_waitrequest = w_cpu_req;
    if (r_state == S_IDLE) begin
      w_grant = w_cpu_req | r_dbg_pending;
      if (w_cpu_req && r_dbg_pending)
        w_pick_dbg = (DBG_PRIO_ON_ACK && debugack) || !r_last_dbg;
      else
        w_pick_dbg = r_dbg_pending;
      if (w_grant && !w_pick_dbg) cpu_waitrequest = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dbg_pending  <= 1'b0;
      r_dbg_we       <= 1'b0;
      r_dbg_wdata    <= '0;
      r_dbg_overflow <= 1'b0;
      r_dbg_rvalid   <= 1'b0;
      r_dbg_rdata    <= '0;
      r_cpu_rvalid   <= 1'b0;
      r_cpu_rdata    <= '0;
      r_dbg_cnt      <= '0;
      r_ram_addr     <= '0;
      r_ram_we       <= 1'b0;
      r_ram_wdata    <= '0;
      r_gnt_dbg      <= 1'b0;
      r_last_dbg     <= 1'b0;
    end else begin
      r_dbg_rvalid <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      if (dbg_addr_load)   r_dbg_cnt <= dbg_addr;
      else if (w_dbg_done) r_dbg_cnt <= r_dbg_cnt + AW'(1);
      if (dbg_req) begin
        if (r_dbg_pending) begin
          r_dbg_overflow <= 1'b1;
        end else begin
          r_dbg_pending <= 1'b1;
          r_dbg_we      <= dbg_write;
          r_dbg_wdata   <= dbg_wdata;
        end
      end
      if (w_dbg_done) r_dbg_pending <= 1'b0;
      if (w_grant) begin
        r_ram_addr  <= w_pick_dbg ? w_dbg_addr  : cpu_address;
        r_ram_we    <= w_pick_dbg ? r_dbg_we    : cpu_write;
        r_ram_wdata <= w_pick_dbg ? r_dbg_wdata : cpu_writedata;
        r_gnt_dbg   <= w_pick_dbg;
        r_last_dbg  <= w_pick_dbg;
      end
      if (r_state == S_CAPTURE) begin
        if (r_gnt_dbg) begin
          r_dbg_rdata  <= ram_rdata;
          r_dbg_rvalid <= 1'b1;
        end else begin
          r_cpu_rdata  <= ram_rdata;
          r_cpu_rvalid <= 1'b1;
        end
      end
    end
  end

  assign dbg_pending       = r_dbg_pending;
  assign dbg_rvalid        = r_dbg_rvalid;
  assign dbg_rdata         = r_dbg_rdata;
  assign dbg_overflow      = r_dbg_overflow;
  assign cpu_readdata      = r_cpu_rdata;
  assign cpu_readdatavalid = r_cpu_rvalid;
  assign ram_we            = r_ram_we;
  assign ram_addr          = r_ram_addr;
  assign ram_wdata         = r_ram_wdata;
endmodule

// File: tb/tb_nios2_debug_ocimem_arbiter.sv
// Directed bench for nios2_debug_ocimem_arbiter with a behavioural RAM and
// read-data scoreboards for the CPU and debug requesters.
module tb_nios2_debug_ocimem_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        debugack = 1'b0;
  logic        dbg_addr_load = 1'b0;
  logic [7:0]  dbg_addr = '0;
  logic        dbg_req = 1'b0, dbg_write = 1'b0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_pending, dbg_rvalid, dbg_overflow;
  logic [31:0] dbg_rdata;
  logic        cpu_read = 1'b0, cpu_write = 1'b0;
  logic [7:0]  cpu_address = '0;
  logic [31:0] cpu_writedata = '0;
  logic        cpu_waitrequest, cpu_readdatavalid;
  logic [31:0] cpu_readdata;
  logic        ram_en, ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  nios2_debug_ocimem_arbiter #(.AW(8), .DBG_PRIO_ON_ACK(1'b1)) dut (
    .clk(clk), .reset(reset), .debugack(debugack),
    .dbg_addr_load(dbg_addr_load), .dbg_addr(dbg_addr), .dbg_req(dbg_req),
    .dbg_write(dbg_write), .dbg_wdata(dbg_wdata), .dbg_pending(dbg_pending),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_overflow(dbg_overflow),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cpu_writedata(cpu_writedata), .cpu_waitrequest(cpu_waitrequest),
    .cpu_readdata(cpu_readdata), .cpu_readdatavalid(cpu_readdatavalid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Single-port RAM with one cycle read latency plus a bench preload port.
  logic [31:0] mem [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  int n_pass = 0, n_fail = 0, n_total = 0;
  logic [31:0] cpu_q[$], dbg_q[$];
  logic [7:0]  glog[$];
  logic        mon_on = 1'b0;
  logic [7:0]  exp3 [6] = '{8'h40, 8'h10, 8'h41, 8'h10, 8'h42, 8'h10};
  logic [7:0]  exp4 [6] = '{8'h40, 8'h41, 8'h42, 8'h10, 8'h10, 8'h10};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (cpu_readdatavalid) begin
        check("cpu_rvalid_expected", 32'(cpu_q.size() > 0), 32'd1);
        if (cpu_q.size() > 0) check("cpu_rdata", cpu_readdata, cpu_q.pop_front());
      end
      if (dbg_rvalid) begin
        check("dbg_rvalid_expected", 32'(dbg_q.size() > 0), 32'd1);
        if (dbg_q.size() > 0) check("dbg_rdata", dbg_rdata, dbg_q.pop_front());
      end
      if (ram_en) glog.push_back(ram_addr);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; dbg_req = 1'b0;
    dbg_addr_load = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic wait_dbg_idle(input string tag);
    int n = 0;
    while (dbg_pending && n < 50) begin tick(); n++; end
    check(tag, 32'(n < 50), 32'd1);
  endtask

  task automatic contention(input logic ack, input int max_pulses);
    int pulses = 1;
    int n = 0;
    logic [7:0] cnt = 8'h41;
    debugack = ack;
    tick();
    glog.delete();
    dbg_addr_load = 1'b1; dbg_addr = 8'h40; dbg_req = 1'b1; dbg_write = 1'b0;
    dbg_q.push_back(mem[8'h40]);
    tick();
    dbg_addr_load = 1'b0; dbg_req = 1'b0; cpu_read = 1'b1; cpu_address = 8'h10;
    while (glog.size() < 6 && n < 80) begin
      @(negedge clk);
      if (ack && dbg_pending) check("prio_cpu_held", 32'(cpu_waitrequest), 32'd1);
      if (!cpu_waitrequest) cpu_q.push_back(mem[8'h10]);
      tick();
      dbg_req = 1'b0;
      if (!dbg_pending && pulses < max_pulses) begin
        dbg_req = 1'b1;
        dbg_q.push_back(mem[cnt]);
        cnt++; pulses++;
      end
      n++;
    end
    cpu_read = 1'b0; dbg_req = 1'b0;
    check("contention_bound", 32'(n < 80), 32'd1);
    wait_dbg_idle("contention_drain");
    repeat (4) tick();
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    do_reset();
    mon_on = 1'b1;
    @(negedge clk);
    check("rst_dbg_pending", 32'(dbg_pending), 32'd0);
    check("rst_dbg_overflow", 32'(dbg_overflow), 32'd0);
    check("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
    check("rst_dbg_rdata", dbg_rdata, 32'd0);
    check("rst_cpu_rvalid", 32'(cpu_readdatavalid), 32'd0);
    check("rst_cpu_rdata", cpu_readdata, 32'd0);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    check("rst_waitreq", 32'(cpu_waitrequest), 32'd0);

    // CPU write then read of 0x05
    tick();
    cpu_write = 1'b1; cpu_address = 8'h05; cpu_writedata = 32'hDEADBEEF;
    @(negedge clk); check("wr_accept_T", 32'(cpu_waitrequest), 32'd0);
    tick(); cpu_write = 1'b0;
    @(negedge clk);
    check("wr_ram_en", 32'(ram_en), 32'd1);
    check("wr_ram_we", 32'(ram_we), 32'd1);
    check("wr_ram_addr", 32'(ram_addr), 32'h05);
    check("wr_ram_wdata", ram_wdata, 32'hDEADBEEF);
    tick(); cpu_read = 1'b1;
    @(negedge clk); check("rd_accept_T", 32'(cpu_waitrequest), 32'd0);
    cpu_q.push_back(32'hDEADBEEF);
    tick(); cpu_read = 1'b0;
    @(negedge clk);
    check("rd_ram_en_T1", 32'(ram_en), 32'd1);
    check("rd_ram_we_T1", 32'(ram_we), 32'd0);
    tick(); @(negedge clk); check("rd_rvalid_T2", 32'(cpu_readdatavalid), 32'd0);
    tick(); @(negedge clk); check("rd_rvalid_T3", 32'(cpu_readdatavalid), 32'd1);
    check("mem05", mem[8'h05], 32'hDEADBEEF);

    // Debug writes across the address wrap, then read back
    tick();
    dbg_addr_load = 1'b1; dbg_addr = 8'hFF; dbg_req = 1'b1; dbg_write = 1'b1;
    dbg_wdata = 32'h11;
    tick(); dbg_addr_load = 1'b0; dbg_req = 1'b0;
    @(negedge clk); check("dbg_pending_set", 32'(dbg_pending), 32'd1);
    wait_dbg_idle("dbg_w1_done"); repeat (3) tick();
    dbg_req = 1'b1; dbg_wdata = 32'h22;
    tick(); dbg_req = 1'b0;
    wait_dbg_idle("dbg_w2_done"); repeat (3) tick();
    check("memFF", mem[8'hFF], 32'h11);
    check("mem00_wrap", mem[8'h00], 32'h22);
    dbg_addr_load = 1'b1; dbg_addr = 8'hFF; dbg_req = 1'b1; dbg_write = 1'b0;
    dbg_q.push_back(32'h11);
    tick(); dbg_addr_load = 1'b0; dbg_req = 1'b0;
    wait_dbg_idle("dbg_r1_done");
    dbg_req = 1'b1; dbg_q.push_back(32'h22);
    tick(); dbg_req = 1'b0;
    wait_dbg_idle("dbg_r2_done"); repeat (4) tick();
    check("dbg_rdata_held", dbg_rdata, 32'h22);

    // Round-robin contention, debugack=0
    do_reset();
    preload(8'h10, 32'hC0C00010);
    for (int unsigned i = 0; i < 6; i++) preload(8'(8'h40 + i), 32'hD0000040 + i);
    contention(1'b0, 10);
    for (int i = 0; i < 6; i++) check($sformatf("rr_grant%0d", i), 32'(glog[i]), 32'(exp3[i]));

    // Debug priority, debugack=1
    do_reset();
    contention(1'b1, 3);
    for (int i = 0; i < 6; i++) check($sformatf("prio_grant%0d", i), 32'(glog[i]), 32'(exp4[i]));
    debugack = 1'b0;

    // Back-to-back dbg_req while the CPU holds the RAM
    do_reset();
    preload(8'h20, 32'h0);
    preload(8'h21, 32'hA5A5A5A5);
    cpu_read = 1'b1; cpu_address = 8'h10;
    @(negedge clk); check("ovf_cpu_accept", 32'(cpu_waitrequest), 32'd0);
    cpu_q.push_back(mem[8'h10]);
    tick(); cpu_read = 1'b0;
    dbg_addr_load = 1'b1; dbg_addr = 8'h20; dbg_req = 1'b1; dbg_write = 1'b1;
    dbg_wdata = 32'h33;
    tick(); dbg_addr_load = 1'b0; dbg_req = 1'b1; dbg_wdata = 32'h44;
    @(negedge clk);
    check("ovf_pending", 32'(dbg_pending), 32'd1);
    check("ovf_before", 32'(dbg_overflow), 32'd0);
    tick(); dbg_req = 1'b0;
    @(negedge clk); check("ovf_set", 32'(dbg_overflow), 32'd1);
    wait_dbg_idle("ovf_done"); repeat (3) tick();
    check("ovf_mem20", mem[8'h20], 32'h33);
    check("ovf_mem21", mem[8'h21], 32'hA5A5A5A5);
    check("ovf_sticky", 32'(dbg_overflow), 32'd1);

    // Reset during CAPTURE of a CPU read
    tick();
    cpu_read = 1'b1; cpu_address = 8'h10;
    @(negedge clk); check("abort_accept", 32'(cpu_waitrequest), 32'd0);
    tick(); cpu_read = 1'b0;
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    @(negedge clk);
    check("abort_rvalid", 32'(cpu_readdatavalid), 32'd0);
    check("abort_rdata", cpu_readdata, 32'd0);
    check("abort_ovf", 32'(dbg_overflow), 32'd0);
    check("abort_ram_en", 32'(ram_en), 32'd0);
    check("abort_ram_addr", 32'(ram_addr), 32'd0);
    check("abort_ram_wdata", ram_wdata, 32'd0);
    check("abort_pending", 32'(dbg_pending), 32'd0);
    tick(); @(negedge clk); check("abort_rvalid_late", 32'(cpu_readdatavalid), 32'd0);
    repeat (3) tick();

    check("cpu_q_empty", 32'(cpu_q.size()), 32'd0);
    check("dbg_q_empty", 32'(dbg_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
